// File: rtl/param_counter_fall_if.sv
// Handshake bundle between a controller and param_counter_fall.
// load/load_val exist only when COUNTER_LOAD_EN is defined.
interface param_counter_fall_if #(
  parameter int WIDTH = 6
);
  logic             start;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
`ifdef COUNTER_LOAD_EN
  logic             load;
  logic [WIDTH-1:0] load_val;
`endif

  modport master (
    output start,
    output en,
`ifdef COUNTER_LOAD_EN
    output load,
    output load_val,
`endif
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  en,
`ifdef COUNTER_LOAD_EN
    input  load,
    input  load_val,
`endif
    output count,
    output busy,
    output done
  );
endinterface

// File: rtl/param_counter_fall.sv
// Run-to-limit counter with start/busy/done handshake, all state on negedge clk.
// Optional preload port enabled by the COUNTER_LOAD_EN macro.
module param_counter_fall #(
  parameter int WIDTH        = 6,
  parameter int LIMIT        = 32,
  parameter int AUTO_RESTART = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  param_counter_fall_if.slave  bus,
  output logic                 dbg_state
);

  if (LIMIT < 1 || LIMIT > (2**WIDTH) - 1) begin : g_bad_limit
    $error("param_counter_fall: LIMIT out of range for WIDTH");
  end

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LIMIT - 1);

  // Handshake: start is accepted only while IDLE; en gates counting only in RUN;
  // done is a one-edge pulse on the terminal edge; busy is high throughout RUN.
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             done_q, done_d;
  logic             hit_term;

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = 1'b0;
    hit_term = 1'b0;
`ifdef COUNTER_LOAD_EN
    if (bus.load) begin
      if (bus.load_val < LIMIT_W) begin
        count_d = bus.load_val;
        state_d = RUN;
      end else begin
        hit_term = 1'b1;
      end
    end else
`endif
    if (state_q == IDLE) begin
      if (bus.start) begin
        count_d = '0;
        state_d = RUN;
      end
    end else if (bus.en) begin
      if (count_q == LAST_W) begin
        hit_term = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    if (hit_term) begin
      // Back-to-back terminal edges (LIMIT=1 wrap, held oversize load) must not
      // merge into a stretched done.
      done_d = !done_q;
      if (AUTO_RESTART != 0) begin
        count_d = '0;
        state_d = RUN;
      end else begin
        count_d = LIMIT_W;
        state_d = IDLE;
      end
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_param_counter_fall.sv
// Directed bench for param_counter_fall: one stop-at-limit and one auto-restart instance.
module tb_param_counter_fall;
  localparam int WIDTH = 6;

  logic clk;
  logic reset;
  logic dbg_a, dbg_b;
  int   errors;
  int   checks;

  param_counter_fall_if #(.WIDTH(WIDTH)) ifa ();
  param_counter_fall_if #(.WIDTH(WIDTH)) ifb ();

  assign ifb.start = ifa.start;
  assign ifb.en    = ifa.en;
`ifdef COUNTER_LOAD_EN
  assign ifb.load     = ifa.load;
  assign ifb.load_val = ifa.load_val;
`endif

  param_counter_fall #(.WIDTH(WIDTH), .LIMIT(32), .AUTO_RESTART(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .dbg_state(dbg_a));
  param_counter_fall #(.WIDTH(WIDTH), .LIMIT(32), .AUTO_RESTART(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .dbg_state(dbg_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c, input int b, input int d);
    chk({tag, ".a.count"}, int'(ifa.count), c);
    chk({tag, ".a.busy"},  int'(ifa.busy),  b);
    chk({tag, ".a.done"},  int'(ifa.done),  d);
  endtask

  task automatic chk_b(input string tag, input int c, input int b, input int d);
    chk({tag, ".b.count"}, int'(ifb.count), c);
    chk({tag, ".b.busy"},  int'(ifb.busy),  b);
    chk({tag, ".b.done"},  int'(ifb.done),  d);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    ifa.start = 1'b0;
    ifa.en = 1'b0;
`ifdef COUNTER_LOAD_EN
    ifa.load = 1'b0;
    ifa.load_val = '0;
`endif

    // 1: reset two edges, then idle; en alone does nothing
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk_a("reset", 0, 0, 0);
    chk("reset.a.dbg", int'(dbg_a), 0);
    chk_b("reset", 0, 0, 0);
    ifa.en = 1'b1;
    tick(); tick(); tick();
    chk_a("idle_en", 0, 0, 0);

    // 2: full run with en held high
    ifa.start = 1'b1;
    tick();
    chk_a("start", 0, 1, 0);
    chk("start.a.dbg", int'(dbg_a), 1);
    ifa.start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      tick();
      chk_a("run", k, 1, 0);
    end
    tick();
    chk_a("term", 32, 0, 1);
    chk("term.a.dbg", int'(dbg_a), 0);
    tick();
    chk_a("after_term", 32, 0, 0);

    // 3: en toggling, start re-pulsed mid-run
    ifa.start = 1'b1;
    tick();
    chk_a("start3", 0, 1, 0);
    ifa.start = 1'b0;
    for (int i = 0; i < 63; i++) begin
      ifa.en = (i % 2 == 1);
      ifa.start = (i == 10 || i == 11);
      tick();
      chk_a("toggle", (i + 1) / 2, 1, 0);
    end
    ifa.en = 1'b1;
    ifa.start = 1'b0;
    tick();
    chk_a("toggle_term", 32, 0, 1);

    // 4: reset mid-run at count 10
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk_a("pre_reset", 10, 1, 0);
    reset = 1'b1;
    tick();
    chk_a("mid_reset", 0, 0, 0);
    chk_b("mid_reset", 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_a("post_reset", 0, 0, 0);

    // 5: auto-restart instance wraps every 32 enabled edges
    ifa.start = 1'b1;
    tick();
    chk_b("ar_start", 0, 1, 0);
    ifa.start = 1'b0;
    for (int k = 1; k <= 96; k++) begin
      tick();
      chk_b("ar_run", k % 32, 1, (k % 32 == 0) ? 1 : 0);
    end

`ifdef COUNTER_LOAD_EN
    // 6: preload below and above LIMIT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ifa.en = 1'b0;
    ifa.load = 1'b1;
    ifa.load_val = 6'd30;
    tick();
    chk_a("load30", 30, 1, 0);
    ifa.load = 1'b0;
    ifa.en = 1'b1;
    tick();
    chk_a("load30_e1", 31, 1, 0);
    tick();
    chk_a("load30_e2", 32, 0, 1);
    tick();
    chk_a("load30_idle", 32, 0, 0);
    ifa.load = 1'b1;
    ifa.load_val = 6'd40;
    tick();
    chk_a("load40", 32, 0, 1);
    chk_b("load40", 0, 1, 1);
    ifa.load = 1'b0;
    ifa.en = 1'b0;
    tick();
    chk_a("load40_next", 32, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
